// File: rtl/jtag_l2_pkg.sv
// jtag_l2_pkg: shared constants and types for the JTAG L2 test block.
//   IR width and instruction codes, TAP state enum, confreg layout,
//   DR widths.
package jtag_l2_pkg;

  localparam int unsigned IR_W = 4;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;
  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h1;
  localparam logic [IR_W-1:0] IR_CONFREG = 4'h6;
  localparam logic [IR_W-1:0] IR_ADDR    = 4'h8;
  localparam logic [IR_W-1:0] IR_DATA    = 4'h9;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;

  localparam int unsigned CONFREG_W = 9;
  localparam int unsigned MODE_LSB  = 1;
  localparam int unsigned MODE_MSB  = 3;
  localparam logic [MODE_MSB-MODE_LSB:0] MODE_JTAG = 3'b001;

  localparam int unsigned DR_W     = 32;
  localparam int unsigned BYPASS_W = 1;

  typedef enum logic [3:0] {
    TAP_RESET,
    TAP_IDLE,
    TAP_SELECT_DR,
    TAP_CAPTURE_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPDATE_DR,
    TAP_SELECT_IR,
    TAP_CAPTURE_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPDATE_IR
  } tap_state_e;

endpackage

// File: rtl/jtag_l2_if.sv
// jtag_l2_if: JTAG probe pin bundle.
//   tck, trst_n, tms, tdi : probe -> device
//   tdo                   : device -> probe
//   master = probe side, slave = device side.
interface jtag_l2_if;
  logic tck;
  logic trst_n;
  logic tms;
  logic tdi;
  logic tdo;

  modport master (output tck, trst_n, tms, tdi, input tdo);
  modport slave  (input tck, trst_n, tms, tdi, output tdo);
endinterface

// File: rtl/jtag_l2_tap_fsm.sv
// jtag_l2_tap_fsm: IEEE 1149.1 16-state TAP controller.
//   clk_i        : system clock
//   trst_ni      : async active-low TAP reset
//   step_i       : one-cycle pulse on detected TCK rising edge
//   tms_i        : synchronized TMS
//   state_o      : current TAP state
//   capture/shift/update strobes for DR and IR, valid with step_i.
//   Capture and shift fire on the step leaving the state; update fires
//   on the step entering Update-xR.
module jtag_l2_tap_fsm
  import jtag_l2_pkg::*;
(
  input  logic       clk_i,
  input  logic       trst_ni,
  input  logic       step_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d, next_state;

  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TAP_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      TAP_RESET:      next_state = tms_i ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:       next_state = tms_i ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_DR:  next_state = tms_i ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: next_state = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   next_state = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   next_state = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   next_state = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   next_state = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  next_state = tms_i ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_IR:  next_state = tms_i ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: next_state = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   next_state = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   next_state = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   next_state = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   next_state = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  next_state = tms_i ? TAP_SELECT_DR : TAP_IDLE;
    endcase

    state_d      = step_i ? next_state : state_q;
    capture_dr_o = step_i && (state_q == TAP_CAPTURE_DR);
    shift_dr_o   = step_i && (state_q == TAP_SHIFT_DR);
    update_dr_o  = step_i && (state_q != TAP_UPDATE_DR) && (next_state == TAP_UPDATE_DR);
    capture_ir_o = step_i && (state_q == TAP_CAPTURE_IR);
    shift_ir_o   = step_i && (state_q == TAP_SHIFT_IR);
    update_ir_o  = step_i && (state_q != TAP_UPDATE_IR) && (next_state == TAP_UPDATE_IR);
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_l2_test.sv
// jtag_l2_test: JTAG-accessible L2 test block.
//   clk_i        : single system clock; JTAG pins are oversampled
//   rst_n        : async active-low reset of the L2 write path
//   jtag_tck_i   : TCK (sampled as data)
//   jtag_trst_ni : async active-low TAP reset (TAP, IR, confreg, address)
//   jtag_tms_i   : TMS
//   jtag_tdi_i   : TDI
//   jtag_tdo_o   : TDO, updated on detected TCK falling edge
//   Instructions: IDCODE, CONFREG, ADDR, DATA, everything else BYPASS.
//   Build option JTAG_L2_AUTOINC_EN: address += 4 on every DATA capture
//   and DATA update.
module jtag_l2_test
  import jtag_l2_pkg::*;
#(
  parameter logic [31:0] IDCODE   = 32'h249511C3,
  parameter int unsigned L2_WORDS = 256
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic jtag_tck_i,
  input  logic jtag_trst_ni,
  input  logic jtag_tms_i,
  input  logic jtag_tdi_i,
  output logic jtag_tdo_o
);

  localparam int unsigned IDX_W = $clog2(L2_WORDS);

  logic [2:0]           tck_sync_q, tck_sync_d;
  logic [1:0]           tms_sync_q, tms_sync_d;
  logic [1:0]           tdi_sync_q, tdi_sync_d;
  logic [IR_W-1:0]      ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DR_W-1:0]      dr_sr_q, dr_sr_d;
  logic [CONFREG_W-1:0] confreg_q, confreg_d;
  logic [DR_W-1:0]      addr_q, addr_d;
  logic                 tdo_q, tdo_d;
  logic                 wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [DR_W-1:0]      wr_data_q, wr_data_d;

  logic [DR_W-1:0]      mem [L2_WORDS];

  logic                 tck_rise, tck_fall, tms, tdi;
  logic                 mem_en;
  logic [IDX_W-1:0]     idx;
  logic [DR_W-1:0]      rd_data;
  tap_state_e           state;
  logic                 capture_dr, shift_dr, update_dr;
  logic                 capture_ir, shift_ir, update_ir;

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms      = tms_sync_q[1];
  assign tdi      = tdi_sync_q[1];

  assign mem_en  = rst_n && (confreg_q[MODE_MSB:MODE_LSB] == MODE_JTAG);
  assign idx     = addr_q[IDX_W+1:2];
  assign rd_data = mem_en ? mem[idx] : '0;

  jtag_l2_tap_fsm u_tap (
    .clk_i        (clk_i),
    .trst_ni      (jtag_trst_ni),
    .step_i       (tck_rise),
    .tms_i        (tms),
    .state_o      (state),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );

  always_comb begin
    tck_sync_d = {tck_sync_q[1:0], jtag_tck_i};
    tms_sync_d = {tms_sync_q[0], jtag_tms_i};
    tdi_sync_d = {tdi_sync_q[0], jtag_tdi_i};
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    dr_sr_d    = dr_sr_q;
    confreg_d  = confreg_q;
    addr_d     = addr_q;
    tdo_d      = tdo_q;

    if (state == TAP_RESET) begin
      ir_d      = IR_IDCODE;
      confreg_d = '0;
      addr_d    = '0;
    end

    if (capture_ir) ir_sr_d = IR_CAPTURE;
    if (shift_ir)   ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
    if (update_ir)  ir_d    = ir_sr_q;

    if (capture_dr) begin
      case (ir_q)
        IR_IDCODE:  dr_sr_d = IDCODE;
        IR_CONFREG: dr_sr_d = DR_W'(confreg_q);
        IR_ADDR:    dr_sr_d = addr_q;
        IR_DATA:    dr_sr_d = rd_data;
        default:    dr_sr_d = '0;
      endcase
    end

    // One shift register serves every DR; the register length decides
    // which bit TDI enters at, TDO always comes from bit 0.
    if (shift_dr) begin
      case (ir_q)
        IR_IDCODE, IR_ADDR, IR_DATA: dr_sr_d = {tdi, dr_sr_q[DR_W-1:1]};
        IR_CONFREG: dr_sr_d[CONFREG_W-1:0] = {tdi, dr_sr_q[CONFREG_W-1:1]};
        default:    dr_sr_d[BYPASS_W-1] = tdi;
      endcase
    end

    if (update_dr) begin
      case (ir_q)
        IR_CONFREG: confreg_d = dr_sr_q[CONFREG_W-1:0];
        IR_ADDR:    addr_d    = dr_sr_q;
        default:    ;
      endcase
    end

`ifdef JTAG_L2_AUTOINC_EN
    if ((capture_dr || update_dr) && (ir_q == IR_DATA)) addr_d = addr_q + 32'd4;
`else
    // Address moves only through ADDR Update-DR.
`endif

    if (tck_fall) begin
      if (state == TAP_SHIFT_IR)      tdo_d = ir_sr_q[0];
      else if (state == TAP_SHIFT_DR) tdo_d = dr_sr_q[0];
      else                            tdo_d = 1'b0;
    end
  end

  always_comb begin
    wr_pend_d = update_dr && (ir_q == IR_DATA) && mem_en;
    wr_idx_d  = wr_pend_d ? idx     : wr_idx_q;
    wr_data_d = wr_pend_d ? dr_sr_q : wr_data_q;
  end

  always_ff @(posedge clk_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      tck_sync_q <= '0;
      tms_sync_q <= '1;
      tdi_sync_q <= '0;
      ir_q       <= IR_IDCODE;
      ir_sr_q    <= '0;
      dr_sr_q    <= '0;
      confreg_q  <= '0;
      addr_q     <= '0;
      tdo_q      <= 1'b0;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      dr_sr_q    <= dr_sr_d;
      confreg_q  <= confreg_d;
      addr_q     <= addr_d;
      tdo_q      <= tdo_d;
    end
  end

  // rst_n clearing wr_pend_q is what drops a pending L2 write.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_pend_q) mem[wr_idx_q] <= wr_data_q;
  end

  assign jtag_tdo_o = tdo_q;

endmodule

// File: tb/tb_jtag_l2_test.sv
// tb_jtag_l2_test: directed JTAG probe sequence against jtag_l2_test with a
// scoreboard of expected scan-out values.
module tb_jtag_l2_test;
  import jtag_l2_pkg::*;

  localparam int unsigned HALF = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_q[$];

  jtag_l2_if jtag ();

  jtag_l2_test #(
    .IDCODE   (32'h249511C3),
    .L2_WORDS (256)
  ) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .jtag_tck_i   (jtag.tck),
    .jtag_trst_ni (jtag.trst_n),
    .jtag_tms_i   (jtag.tms),
    .jtag_tdi_i   (jtag.tdi),
    .jtag_tdo_o   (jtag.tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // TDO is sampled just before TCK rises, as a probe would.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    jtag.tms = tms;
    jtag.tdi = tdi;
    repeat (HALF) @(negedge clk);
    tdo = jtag.tdo;
    jtag.tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag.tck = 1'b0;
  endtask

  // Idle -> Capture-DR -> Shift-DR (len bits) -> Update-DR -> Idle
  task automatic dr_scan(input int unsigned len, input logic [31:0] din,
                         output logic [31:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int unsigned i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic ir_scan(input logic [3:0] code, output logic [31:0] cap);
    logic b;
    cap = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int unsigned i = 0; i < 4; i++) begin
      tck_cycle(i == 3, code[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  initial begin
    logic [31:0] v;
    logic        b;
    vectors     = 0;
    miscompares = 0;
    jtag.tck    = 1'b0;
    jtag.tms    = 1'b1;
    jtag.tdi    = 1'b0;
    jtag.trst_n = 1'b0;
    rst_n       = 1'b0;
    repeat (10) @(negedge clk);

    exp_q.push_back(32'h0);
    check("reset_tdo", {31'b0, jtag.tdo});

    jtag.trst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int unsigned i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);

    exp_q.push_back(32'h249511C3);
    dr_scan(32, 32'h0, v);
    check("idcode_default_ir", v);

    exp_q.push_back(32'h5);
    ir_scan(IR_BYPASS, v);
    check("ir_capture_bypass", v);

    // 0xA5 shifted through the 1-bit bypass comes out one TCK late.
    exp_q.push_back(32'h14A);
    dr_scan(9, 32'h0A5, v);
    check("bypass_delay", v);

    // confreg programmed while rst_n is still low
    exp_q.push_back(32'h5);
    ir_scan(IR_CONFREG, v);
    check("ir_capture_confreg", v);
    exp_q.push_back(32'h0);
    dr_scan(9, 32'h002, v);
    check("confreg_reset_value", v);
    exp_q.push_back(32'h002);
    dr_scan(9, 32'h002, v);
    check("confreg_written_in_rst", v);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    exp_q.push_back(32'h5);
    ir_scan(IR_ADDR, v);
    check("ir_capture_addr", v);
    exp_q.push_back(32'h0);
    dr_scan(32, 32'h0, v);
    check("addr_reset_value", v);

    ir_scan(IR_DATA, v);
    dr_scan(32, 32'hABBAABBA, v);
    ir_scan(IR_ADDR, v);
    exp_q.push_back(32'h0);
    dr_scan(32, 32'h4, v);
    check("addr_read_back_0", v);
    ir_scan(IR_DATA, v);
    dr_scan(32, 32'h11223344, v);

    ir_scan(IR_ADDR, v);
    exp_q.push_back(32'h4);
    dr_scan(32, 32'h0, v);
    check("addr_read_back_4", v);
    ir_scan(IR_DATA, v);
    exp_q.push_back(32'hABBAABBA);
    dr_scan(32, 32'hABBAABBA, v);
    check("data_read_word0", v);

    // disable memory access (mode 000)
    ir_scan(IR_CONFREG, v);
    exp_q.push_back(32'h002);
    dr_scan(9, 32'h000, v);
    check("confreg_before_disable", v);
    ir_scan(IR_ADDR, v);
    exp_q.push_back(32'h0);
    dr_scan(32, 32'h4, v);
    check("addr_before_disabled_wr", v);
    ir_scan(IR_DATA, v);
    exp_q.push_back(32'h0);
    dr_scan(32, 32'h12345678, v);
    check("data_read_disabled", v);

    ir_scan(IR_CONFREG, v);
    exp_q.push_back(32'h000);
    dr_scan(9, 32'h002, v);
    check("confreg_disabled", v);

    // 0x407: low bits ignored, index wraps to word 1
    ir_scan(IR_ADDR, v);
    exp_q.push_back(32'h4);
    dr_scan(32, 32'h407, v);
    check("addr_before_wrap", v);
    ir_scan(IR_DATA, v);
    exp_q.push_back(32'h11223344);
    dr_scan(32, 32'h0, v);
    check("data_wrap_old_content", v);

    // TRST in the middle of a CONFREG shift
    exp_q.push_back(32'h5);
    ir_scan(IR_CONFREG, v);
    check("ir_capture_pre_trst", v);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int unsigned i = 0; i < 4; i++) tck_cycle(1'b0, 1'b1, b);
    jtag.trst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h0);
    check("trst_tdo", {31'b0, jtag.tdo});
    repeat (4) @(negedge clk);
    jtag.trst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, b);

    exp_q.push_back(32'h249511C3);
    dr_scan(32, 32'h0, v);
    check("trst_ir_idcode", v);
    ir_scan(IR_CONFREG, v);
    exp_q.push_back(32'h0);
    dr_scan(9, 32'h0, v);
    check("trst_confreg_cleared", v);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
